// File: rtl/fns_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// fns_cfg_sequencer
//
// Configuration controller for a fault-tolerant Fibonacci-numeral-system TSV
// codec. When a start request arrives, it latches the per-TSV fault flags. It
// then walks the bundle one TSV per cycle, starting at the LSB. Each fault-free
// TSV receives the next Fibonacci weight (1, 2, 3, 5, ...) until K = N_TSV-N_RED
// weights have been handed out. Faulty TSVs are disabled, and so are good spares
// that are left over once all K weights are allocated. If the bundle holds fewer
// than K good TSVs, the scan ends with cfg_fail and an all-zero configuration.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : single-cycle configuration request (ignored while busy)
//   f_flag     : per-TSV fault flags, bit i = TSV i, 1 = faulty
//   busy       : high while the scan is in progress
//   done       : one-cycle pulse after the final TSV has been processed
//   cfg_valid  : en_flag/weight_bus hold a valid configuration
//   cfg_fail   : last scan found fewer than K good TSVs
//   en_flag    : per-TSV data enable
//   weight_bus : W-bit weight per TSV, TSV i in bits [i*W +: W]
// ---------------------------------------------------------------------------
module fns_cfg_sequencer #(
   parameter int N_TSV = 6,
   parameter int N_RED = 2,
   parameter int W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N_TSV-1:0]   f_flag,
   output logic               busy,
   output logic               done,
   output logic               cfg_valid,
   output logic               cfg_fail,
   output logic [N_TSV-1:0]   en_flag,
   output logic [N_TSV*W-1:0] weight_bus
);

   localparam int K     = N_TSV - N_RED;
   localparam int IDX_W = (N_TSV > 1) ? $clog2(N_TSV) : 1;
   localparam int CNT_W = (K > 0) ? $clog2(K + 1) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TSV - 1);
   localparam logic [CNT_W-1:0] K_CNT    = CNT_W'(K);

   // Fib(n) with Fib(1) = Fib(2) = 1. The largest weight handed out is Fib(K+1).
   function automatic int fib(input int n);
      int a;
      int b;
      int t;
      a = 0;
      b = 1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   localparam bit FIB_FITS = (fib(K + 1) <= ((2 ** W) - 1));

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   alloc_q, alloc_d;
   logic [W-1:0]       p2_q, p2_d;
   logic [W-1:0]       p1_q, p1_d;
   logic [N_TSV-1:0]   f_q, f_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cfg_valid_q, cfg_valid_d;
   logic               cfg_fail_q, cfg_fail_d;
   logic [N_TSV-1:0]   en_q, en_d;
   logic [N_TSV*W-1:0] weight_q, weight_d;

   logic [W-1:0]       fib_sum;
   logic [CNT_W-1:0]   alloc_inc;
   logic [CNT_W-1:0]   alloc_fin;

   // Next-state logic. The pair (p2, p1) always holds the two previous
   // weights, so p2+p1 is the weight for the next good TSV. The final
   // allocation count includes the TSV that is processed on the last edge.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      alloc_d     = alloc_q;
      p2_d        = p2_q;
      p1_d        = p1_q;
      f_d         = f_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cfg_valid_d = cfg_valid_q;
      cfg_fail_d  = cfg_fail_q;
      en_d        = en_q;
      weight_d    = weight_q;
      fib_sum     = p2_q + p1_q;
      alloc_inc   = alloc_q + CNT_W'(1);
      alloc_fin   = alloc_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = SCAN;
               f_d         = f_flag;
               en_d        = '0;
               weight_d    = '0;
               cfg_valid_d = 1'b0;
               cfg_fail_d  = 1'b0;
               idx_d       = '0;
               alloc_d     = '0;
               p2_d        = '0;
               p1_d        = W'(1);
               busy_d      = 1'b1;
            end
         end

         SCAN: begin
            if (f_q[idx_q]) begin
               en_d[idx_q]                   = 1'b0;
               weight_d[int'(idx_q)*W +: W]  = '0;
            end else if (alloc_q < K_CNT) begin
               en_d[idx_q]                   = 1'b1;
               weight_d[int'(idx_q)*W +: W]  = fib_sum;
               p2_d                          = p1_q;
               p1_d                          = fib_sum;
               alloc_d                       = alloc_inc;
               alloc_fin                     = alloc_inc;
            end else begin
               // Good spare: all data weights are already placed.
               en_d[idx_q]                   = 1'b0;
               weight_d[int'(idx_q)*W +: W]  = '0;
            end

            idx_d = idx_q + IDX_W'(1);

            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               idx_d   = '0;
               if (alloc_fin == K_CNT) begin
                  cfg_valid_d = 1'b1;
               end else begin
                  // Not enough good TSVs: present an all-off configuration.
                  cfg_fail_d = 1'b1;
                  en_d       = '0;
                  weight_d   = '0;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. An asynchronous reset aborts any scan in
   // progress without producing a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         alloc_q     <= '0;
         p2_q        <= '0;
         p1_q        <= '0;
         f_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_valid_q <= 1'b0;
         cfg_fail_q  <= 1'b0;
         en_q        <= '0;
         weight_q    <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         alloc_q     <= alloc_d;
         p2_q        <= p2_d;
         p1_q        <= p1_d;
         f_q         <= f_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_fail_q  <= cfg_fail_d;
         en_q        <= en_d;
         weight_q    <= weight_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_valid  = cfg_valid_q;
   assign cfg_fail   = cfg_fail_q;
   assign en_flag    = en_q;
   assign weight_bus = weight_q;

   // The largest Fibonacci weight must fit in a W-bit field.
   a_fib_fits_weight: assert property (@(posedge clk) FIB_FITS);

   // A scan result is either valid or failed, never both.
   a_valid_fail_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(cfg_valid_q && cfg_fail_q));

endmodule

// File: tb/tb_fns_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fns_cfg_sequencer
//
// Directed testbench for fns_cfg_sequencer. A behavioural model derives the
// expected configuration straight from the fault flags (count the good TSVs,
// then give the first K of them the Fibonacci weights 1,2,3,5,...) and tracks
// the N_TSV-cycle scan timing. A compare process checks the DUT against the
// model on every falling edge. Each scan also checks literal expected values.
// ---------------------------------------------------------------------------
module tb_fns_cfg_sequencer;

   localparam int N_TSV = 6;
   localparam int N_RED = 2;
   localparam int W     = 4;
   localparam int K     = N_TSV - N_RED;

   logic               clk    = 1'b0;
   logic               rst_n  = 1'b0;
   logic               start  = 1'b0;
   logic [N_TSV-1:0]   f_flag = '0;
   logic               busy;
   logic               done;
   logic               cfg_valid;
   logic               cfg_fail;
   logic [N_TSV-1:0]   en_flag;
   logic [N_TSV*W-1:0] weight_bus;

   int n_compared   = 0;
   int n_mismatched = 0;
   bit check_en     = 1'b0;

   fns_cfg_sequencer #(
      .N_TSV(N_TSV),
      .N_RED(N_RED),
      .W    (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .f_flag    (f_flag),
      .busy      (busy),
      .done      (done),
      .cfg_valid (cfg_valid),
      .cfg_fail  (cfg_fail),
      .en_flag   (en_flag),
      .weight_bus(weight_bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Shared comparison routine: counts every check and reports any mismatch.
   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Computes the final configuration for a given set of fault flags.
   task automatic compute_config(input logic [N_TSV-1:0] flags,
                                 output logic [N_TSV-1:0] en,
                                 output logic [N_TSV*W-1:0] wb,
                                 output bit ok);
      int good;
      int n;
      int wts[$];
      good = 0;
      for (int i = 0; i < N_TSV; i++) if (!flags[i]) good++;
      ok = (good >= K);
      en = '0;
      wb = '0;
      wts.push_back(1);
      wts.push_back(2);
      while (wts.size() < K) wts.push_back(wts[wts.size()-1] + wts[wts.size()-2]);
      if (ok) begin
         n = 0;
         for (int i = 0; i < N_TSV; i++) begin
            if (!flags[i] && n < K) begin
               en[i]         = 1'b1;
               wb[i*W +: W]  = W'(wts[n]);
               n++;
            end
         end
      end
   endtask

   // Model state
   bit                 m_busy   = 1'b0;
   bit                 m_done   = 1'b0;
   bit                 m_valid  = 1'b0;
   bit                 m_fail   = 1'b0;
   logic [N_TSV-1:0]   m_en     = '0;
   logic [N_TSV*W-1:0] m_weight = '0;
   int                 m_cnt    = 0;
   logic [N_TSV-1:0]   m_res_en;
   logic [N_TSV*W-1:0] m_res_w;
   bit                 m_res_ok;

   // Model: an accepted start computes the result at once. The result becomes
   // visible together with done, N_TSV edges later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy   = 1'b0;
         m_done   = 1'b0;
         m_valid  = 1'b0;
         m_fail   = 1'b0;
         m_en     = '0;
         m_weight = '0;
         m_cnt    = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_cnt++;
            if (m_cnt == N_TSV) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               if (m_res_ok) begin
                  m_valid  = 1'b1;
                  m_en     = m_res_en;
                  m_weight = m_res_w;
               end else begin
                  m_fail = 1'b1;
               end
            end
         end else if (start) begin
            compute_config(f_flag, m_res_en, m_res_w, m_res_ok);
            m_busy   = 1'b1;
            m_cnt    = 0;
            m_valid  = 1'b0;
            m_fail   = 1'b0;
            m_en     = '0;
            m_weight = '0;
         end
      end
   end

   // Per-cycle comparison against the model. The configuration outputs are
   // compared only outside a scan, because partial values are not meaningful.
   always @(negedge clk) begin
      if (check_en) begin
         check_output("busy",      64'(busy),      64'(m_busy));
         check_output("done",      64'(done),      64'(m_done));
         check_output("cfg_valid", 64'(cfg_valid), 64'(m_valid));
         check_output("cfg_fail",  64'(cfg_fail),  64'(m_fail));
         if (!m_busy) begin
            check_output("en_flag",    64'(en_flag),    64'(m_en));
            check_output("weight_bus", 64'(weight_bus), 64'(m_weight));
         end
      end
   end

   // Issues one scan and waits for done (bounded). It optionally glitches
   // start and f_flag mid-scan, then checks the hand-computed expected result.
   task automatic apply_stimulus(input logic [N_TSV-1:0] flags, input int gap,
                                 input int glitch_cycle,
                                 input logic [N_TSV-1:0] glitch_flags,
                                 input logic [N_TSV-1:0] exp_en,
                                 input logic [N_TSV*W-1:0] exp_w,
                                 input bit exp_valid);
      int cycles;
      int dones;
      bit seen;
      repeat (gap) @(negedge clk);
      start  = 1'b1;
      f_flag = flags;
      @(posedge clk);
      #2;
      start  = 1'b0;
      cycles = 0;
      dones  = 0;
      seen   = 1'b0;
      while (!seen && cycles < 50) begin
         if (glitch_cycle != 0 && cycles == glitch_cycle) begin
            start  = 1'b1;
            f_flag = glitch_flags;
         end
         @(posedge clk);
         #2;
         start = 1'b0;
         cycles++;
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            dones++;
         end
      end
      check_output("scan_latency", 64'(cycles), 64'(N_TSV));
      check_output("lit_busy",     64'(busy),      64'(0));
      check_output("lit_valid",    64'(cfg_valid), 64'(exp_valid));
      check_output("lit_fail",     64'(cfg_fail),  64'(!exp_valid));
      check_output("lit_en",       64'(en_flag),   64'(exp_en));
      check_output("lit_weight",   64'(weight_bus), 64'(exp_w));
      if (glitch_cycle != 0) begin
         repeat (3) begin
            @(negedge clk);
            if (done) dones++;
         end
         check_output("done_once", 64'(dones), 64'(1));
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_busy",   64'(busy),       64'(0));
      check_output("rst_done",   64'(done),       64'(0));
      check_output("rst_valid",  64'(cfg_valid),  64'(0));
      check_output("rst_fail",   64'(cfg_fail),   64'(0));
      check_output("rst_en",     64'(en_flag),    64'(0));
      check_output("rst_weight", 64'(weight_bus), 64'(0));
      check_en = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // No faults: the two top TSVs are spares.
      apply_stimulus(6'b000000, 1, 0, '0, 6'b001111, 24'h005321, 1'b1);
      // Back-to-back starts in the done cycle with different fault patterns.
      apply_stimulus(6'b000101, 0, 0, '0, 6'b111010, 24'h532010, 1'b1);
      apply_stimulus(6'b000111, 0, 0, '0, 6'b000000, 24'h000000, 1'b0);
      apply_stimulus(6'b010100, 0, 0, '0, 6'b101011, 24'h503021, 1'b1);
      apply_stimulus(6'b110001, 2, 0, '0, 6'b000000, 24'h000000, 1'b0);
      apply_stimulus(6'b000011, 0, 0, '0, 6'b111100, 24'h532100, 1'b1);
      apply_stimulus(6'b100000, 3, 0, '0, 6'b001111, 24'h005321, 1'b1);
      // Restart plus flag change mid-scan must be ignored.
      apply_stimulus(6'b000101, 1, 3, 6'b111111, 6'b111010, 24'h532010, 1'b1);

      // Reset in the middle of a scan
      @(negedge clk);
      start  = 1'b1;
      f_flag = 6'b000000;
      @(posedge clk);
      #2;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_busy",   64'(busy),       64'(0));
      check_output("mid_rst_done",   64'(done),       64'(0));
      check_output("mid_rst_valid",  64'(cfg_valid),  64'(0));
      check_output("mid_rst_fail",   64'(cfg_fail),   64'(0));
      check_output("mid_rst_en",     64'(en_flag),    64'(0));
      check_output("mid_rst_weight", 64'(weight_bus), 64'(0));
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check_output("no_done_after_rst", 64'(done), 64'(0));
      end
      apply_stimulus(6'b000000, 0, 0, '0, 6'b001111, 24'h005321, 1'b1);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/fns_cfg_sequencer.md
Name: fns_cfg_sequencer

Overview:
- Sequential configuration controller for the fault-tolerant Fibonacci-numeral-system (FNS) TSV codec.
- On a start request it samples the per-TSV fault flags and walks the TSV bundle one TSV per cycle, LSB first.
- Each fault-free TSV receives the next Fibonacci weight and an enable flag; faulty TSVs, and spare TSVs left over once all data weights are allocated, are disabled.
- Its outputs drive the codec's weight and enable registers.

Parameters:
- N_TSV, 6, total TSVs in the bundle (data plus redundant, x+y).
- N_RED, 2, redundant TSVs (y). K = N_TSV-N_RED is the number of data weights to allocate.
- W, 4, width of each weight field. Must satisfy Fib(K+1) <= 2^W-1; this is a static constraint checked by assertion.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle configuration request.
- f_flag  input  N_TSV  fault flags; bit 0 is TSV0; 1 = faulty; sampled only on an accepted start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when a scan completes (pass or fail).
- cfg_valid  output  1  level; en_flag and weight_bus hold a valid configuration.
- cfg_fail  output  1  level; the last scan found fewer than K good TSVs.
- en_flag  output  N_TSV  per-TSV enable; 1 = TSV carries data.
- weight_bus  output  N_TSV*W  weight of TSV i in bits [i*W+W-1 : i*W].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, cfg_valid, cfg_fail = 0; en_flag = 0; weight_bus = 0.
  - Internal index, allocation count and Fibonacci pair registers are cleared.
  - Reset mid-scan aborts immediately; no done pulse is produced.
- States: IDLE, SCAN.
- IDLE, edge E0 with start=1 (accepted start):
  - Latch f_flag.
  - Clear en_flag, weight_bus, cfg_valid and cfg_fail.
  - idx=0, alloc=0, pair (p2,p1)=(0,1).
  - Go to SCAN; busy=1 from E0.
- SCAN processes TSV idx on each edge E1..E_N (N=N_TSV):
  - If f[idx]=1: en[idx]=0, weight[idx]=0, pair unchanged.
  - Else if alloc<K: en[idx]=1, weight[idx]=p2+p1 (W-bit add), pair <= (p1, p2+p1), alloc++.
  - Else (good spare, K already allocated): en[idx]=0, weight[idx]=0.
  - idx++.
  - The resulting weight sequence over good TSVs is 1, 2, 3, 5, 8, ...
- On the edge processing idx=N-1 (E_N):
  - Next state = IDLE; busy=0 after E_N; done=1 for exactly the cycle after E_N.
  - If the final alloc (including this TSV) equals K: cfg_valid=1.
  - Else: cfg_fail=1, en_flag forced to all 0, weight_bus forced to 0 on that same edge.
- Latency: fixed N_TSV cycles from the start edge to the final edge. done is visible N_TSV cycles after E0, independent of the fault pattern.
- start while busy is ignored and has no effect on the scan.
- start in the done cycle (state already IDLE) is accepted; the new scan clears cfg_valid and cfg_fail at that edge.
- cfg_valid and cfg_fail are mutually exclusive. Both hold until the next accepted start or reset.
- en_flag and weight_bus change only during SCAN; they are stable while cfg_valid=1.
- Fault flags changing during SCAN are ignored; the latched copy is used.
- Partial outputs during SCAN are not valid; consumers must qualify them with cfg_valid.

Test Plan:
- Reset, then start with f_flag=6'b000000 -> busy 6 cycles; done after 6 cycles; en_flag=6'b001111; weights TSV0..5 = 1,2,3,5,0,0; cfg_valid=1, cfg_fail=0.
- f_flag=6'b000101 -> en_flag=6'b111010; weights TSV0..5 = 0,1,0,2,3,5; cfg_valid=1.
- f_flag=6'b010100 -> en_flag=6'b101011; weights TSV0..5 = 1,2,0,3,0,5; cfg_valid=1.
- f_flag=6'b000111 (only 3 good) -> done after 6 cycles; cfg_fail=1, cfg_valid=0; en_flag=0; weight_bus=0.
- start pulsed again at cycle 3 of a scan, and f_flag toggled mid-scan -> ignored; result matches the flags latched at the original start; done pulses once.
- rst_n low at cycle 2 of a scan -> all outputs 0 immediately and no done pulse; a fresh start after release gives the normal 6-cycle result.
